// File: rtl/gpio_cmd_master.sv
`default_nettype none
// +------------------------------------------------------------------------------------------+
// | gpio_cmd_master: queued command initiator driving the GPIO register-file handshake.      |
// | Define GPIO_CMD_MASTER_RDBK_EN to enable the post-command gpi readback.  Rev 1.0         |
// +------------------------------------------------------------------------------------------+
module gpio_cmd_master #(
  parameter int FIFO_DEPTH = 4,
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 1,
  parameter int HOLD_CYC   = 2,
  parameter int READ_WAIT  = 2
) (
  input  logic        clock100,
  input  logic        i_reset,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [7:0]  i_cmd_op,
  input  logic [22:0] i_cmd_data,
  input  logic        i_cmd_rd,
  output logic [31:0] o_gpo,
  input  logic [31:0] i_gpi,
  output logic [31:0] o_rdata,
  output logic        o_rvalid,
  output logic        o_busy,
  output logic        o_done
);

`ifdef GPIO_CMD_MASTER_RDBK_EN
  localparam bit C_RDBK_EN = 1'b1;
`else
  localparam bit C_RDBK_EN = 1'b0;
`endif

  localparam int C_PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int C_MAX_A   = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int C_MAX_B   = (HOLD_CYC > READ_WAIT) ? HOLD_CYC : READ_WAIT;
  localparam int C_MAX_CYC = (C_MAX_A > C_MAX_B) ? C_MAX_A : C_MAX_B;
  localparam int C_CNT_W   = (C_MAX_CYC > 1) ? $clog2(C_MAX_CYC) : 1;
  localparam logic [C_PTR_W:0]   C_PTR_ONE = 1;
  localparam logic [C_CNT_W-1:0] C_CNT_ONE = 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_RDWAIT = 3'd4
  } state_t;

  // Queue entry layout: {rd, op[7:0], data[22:0]}
  logic [31:0]        r_fifo_mem [FIFO_DEPTH];
  logic [C_PTR_W:0]   r_wr_ptr;
  logic [C_PTR_W:0]   r_rd_ptr;
  logic               w_empty;
  logic               w_full;
  logic               w_push;
  logic               w_pop;
  logic [31:0]        w_head;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [C_CNT_W-1:0] r_cnt;
  logic [C_CNT_W-1:0] w_cnt_nxt;
  logic [31:0]        r_gpo;
  logic [31:0]        w_gpo_nxt;
  logic               r_rd;
  logic               w_rd_nxt;
  logic [31:0]        r_rdata;
  logic [31:0]        w_rdata_nxt;
  logic               r_rvalid;
  logic               w_rvalid_nxt;
  logic               r_done;
  logic               w_done_nxt;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[C_PTR_W] != r_rd_ptr[C_PTR_W]) &&
                   (r_wr_ptr[C_PTR_W-1:0] == r_rd_ptr[C_PTR_W-1:0]);
  assign w_push  = i_cmd_valid && !w_full;
  assign w_head  = r_fifo_mem[r_rd_ptr[C_PTR_W-1:0]];

  always_ff @(posedge clock100) begin
    if (w_push) begin
      r_fifo_mem[r_wr_ptr[C_PTR_W-1:0]] <= {i_cmd_rd, i_cmd_op, i_cmd_data};
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_gpo_nxt    = r_gpo;
    w_rd_nxt     = r_rd;
    w_rdata_nxt  = r_rdata;
    w_rvalid_nxt = 1'b0;
    w_done_nxt   = 1'b0;
    w_pop        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_gpo_nxt   = {w_head[30:23], 1'b0, w_head[22:0]};
          w_rd_nxt    = w_head[31] & C_RDBK_EN;
          w_cnt_nxt   = C_CNT_W'(SETUP_CYC - 1);
          w_state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (r_cnt == '0) begin
          w_gpo_nxt[23] = 1'b1;
          w_cnt_nxt     = C_CNT_W'(STROBE_CYC - 1);
          w_state_nxt   = ST_STROBE;
        end else begin
          w_cnt_nxt = r_cnt - C_CNT_ONE;
        end
      end
      ST_STROBE: begin
        if (r_cnt == '0) begin
          w_gpo_nxt[23] = 1'b0;
          w_cnt_nxt     = C_CNT_W'(HOLD_CYC - 1);
          w_state_nxt   = ST_HOLD;
        end else begin
          w_cnt_nxt = r_cnt - C_CNT_ONE;
        end
      end
      ST_HOLD: begin
        if (r_cnt == '0) begin
          if (r_rd) begin
            w_cnt_nxt   = C_CNT_W'(READ_WAIT - 1);
            w_state_nxt = ST_RDWAIT;
          end else begin
            w_done_nxt  = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - C_CNT_ONE;
        end
      end
      ST_RDWAIT: begin
        if (r_cnt == '0) begin
          w_rdata_nxt  = i_gpi;
          w_rvalid_nxt = 1'b1;
          w_done_nxt   = 1'b1;
          w_state_nxt  = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - C_CNT_ONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock100) begin
    if (i_reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_gpo    <= '0;
      r_rd     <= 1'b0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_done   <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_gpo    <= w_gpo_nxt;
      r_rd     <= w_rd_nxt;
      r_rdata  <= w_rdata_nxt;
      r_rvalid <= w_rvalid_nxt;
      r_done   <= w_done_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
    end
  end

  assign o_cmd_ready = !w_full;
  assign o_gpo       = r_gpo;
  assign o_rdata     = r_rdata;
  assign o_rvalid    = r_rvalid;
  assign o_done      = r_done;
  assign o_busy      = (r_state != ST_IDLE) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_gpio_cmd_master.sv
`default_nettype none
// +------------------------------------------------------------------------------------------+
// | tb_gpio_cmd_master: random and directed stimulus against a timeline model.  Rev 1.0      |
// +------------------------------------------------------------------------------------------+
module tb_gpio_cmd_master;
  localparam int DEPTH = 4;
  localparam int SETUP = 2;
  localparam int STROBE = 1;
  localparam int HOLD = 2;
  localparam int RWAIT = 2;
`ifdef GPIO_CMD_MASTER_RDBK_EN
  localparam bit RDBK = 1'b1;
`else
  localparam bit RDBK = 1'b0;
`endif

  logic        clock100 = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_cmd_valid = 1'b0;
  logic        o_cmd_ready;
  logic [7:0]  i_cmd_op = '0;
  logic [22:0] i_cmd_data = '0;
  logic        i_cmd_rd = 1'b0;
  logic [31:0] o_gpo;
  logic [31:0] i_gpi = '0;
  logic [31:0] o_rdata;
  logic        o_rvalid;
  logic        o_busy;
  logic        o_done;

  gpio_cmd_master #(.FIFO_DEPTH(DEPTH), .SETUP_CYC(SETUP), .STROBE_CYC(STROBE),
                    .HOLD_CYC(HOLD), .READ_WAIT(RWAIT)) dut (
    .clock100(clock100), .i_reset(i_reset), .i_cmd_valid(i_cmd_valid),
    .o_cmd_ready(o_cmd_ready), .i_cmd_op(i_cmd_op), .i_cmd_data(i_cmd_data),
    .i_cmd_rd(i_cmd_rd), .o_gpo(o_gpo), .i_gpi(i_gpi), .o_rdata(o_rdata),
    .o_rvalid(o_rvalid), .o_busy(o_busy), .o_done(o_done));

  always #5 clock100 = ~clock100;

  // Each accepted command is reduced to its push / pop / done cycle numbers.
  typedef struct {
    int          push;
    int          pop;
    int          done;
    logic [31:0] word;
    bit          rd;
    logic [31:0] rdata;
  } cmd_t;
  cmd_t cmds[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  bit clear_pending = 1'b0;
  bit acc;
  bit gpi_force = 1'b0;
  logic [31:0] gpi_val = '0;
  logic [31:0] obs_gpo;
  logic        obs_ready, obs_busy, obs_done, obs_rvalid;
  logic [31:0] obs_rdata;
  bit          prev23 = 1'b0;
  int          n_strobes = 0;
  int          n_long = 0;
  logic [7:0]  strobe_ops[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", tag, cyc, act, exp);
    end
  endtask

  function automatic int occupancy(input int t);
    int n = 0;
    foreach (cmds[i]) if (cmds[i].push < t && cmds[i].pop >= t) n++;
    return n;
  endfunction

  task automatic step(input bit v, input logic [7:0] op, input logic [22:0] data,
                      input bit rd, input bit rst);
    cmd_t c;
    bit e_ready, e_busy, e_done, e_rvalid;
    logic [31:0] e_gpo, e_rdata;
    @(posedge clock100);
    #1;
    cyc++;
    if (clear_pending) begin
      cmds.delete();
      clear_pending = 1'b0;
    end
    i_cmd_valid = v;
    i_cmd_op = op;
    i_cmd_data = data;
    i_cmd_rd = rd;
    i_reset = rst;
    i_gpi = gpi_force ? gpi_val : $urandom();
    e_ready = (occupancy(cyc) < DEPTH);
    acc = v && e_ready && !rst;
    if (acc) begin
      c.push = cyc;
      c.pop = cyc + 1;
      if (cmds.size() > 0 && cmds[$].done > c.pop) c.pop = cmds[$].done;
      c.rd = rd & RDBK;
      c.done = c.pop + 1 + SETUP + STROBE + HOLD + (c.rd ? RWAIT : 0);
      c.word = {op, 1'b0, data};
      c.rdata = '0;
      cmds.push_back(c);
    end
    foreach (cmds[i]) if (cmds[i].rd && cmds[i].done - 1 == cyc) cmds[i].rdata = i_gpi;

    @(negedge clock100);
    e_gpo = '0; e_rdata = '0; e_busy = 0; e_done = 0; e_rvalid = 0;
    foreach (cmds[i]) begin
      if (cmds[i].pop < cyc) begin
        e_gpo = cmds[i].word;
        if (cyc >= cmds[i].pop + 1 + SETUP && cyc < cmds[i].pop + 1 + SETUP + STROBE)
          e_gpo[23] = 1'b1;
      end
      if (cmds[i].push < cyc && cyc < cmds[i].done) e_busy = 1;
      if (cmds[i].done == cyc) begin
        e_done = 1;
        if (cmds[i].rd) e_rvalid = 1;
      end
      if (cmds[i].rd && cmds[i].done <= cyc) e_rdata = cmds[i].rdata;
    end
    obs_gpo = o_gpo; obs_ready = o_cmd_ready; obs_busy = o_busy;
    obs_done = o_done; obs_rvalid = o_rvalid; obs_rdata = o_rdata;
    check("gpo", o_gpo, e_gpo);
    check("cmd_ready", {31'b0, o_cmd_ready}, {31'b0, e_ready});
    check("busy", {31'b0, o_busy}, {31'b0, e_busy});
    check("done", {31'b0, o_done}, {31'b0, e_done});
    check("rvalid", {31'b0, o_rvalid}, {31'b0, e_rvalid});
    check("rdata", o_rdata, e_rdata);
    if (o_gpo[23] === 1'b1 && !prev23) begin
      n_strobes++;
      strobe_ops.push_back(o_gpo[31:24]);
    end
    if (o_gpo[23] === 1'b1 && prev23) n_long++;
    prev23 = (o_gpo[23] === 1'b1);
    if (rst) clear_pending = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 8'h00, 23'h0, 1'b0, 1'b0);
  endtask

  logic [31:0] seen_gpo [0:15];
  logic        seen_done [0:15];
  logic        seen_rv [0:15];
  logic [31:0] seen_rd [0:15];
  logic        r5;
  int          tries;
  int          dcount;
  int          bcount;
  bit          rv, rr;

  initial begin
    // Reset held for three cycles
    for (int k = 0; k < 3; k++) step(1'b0, 8'h00, 23'h0, 1'b0, 1'b1);
    check("rst_gpo", obs_gpo, 32'h0);
    check("rst_ready", {31'b0, obs_ready}, 32'h1);
    check("rst_busy", {31'b0, obs_busy}, 32'h0);
    check("rst_rvalid", {31'b0, obs_rvalid}, 32'h0);
    check("rst_done", {31'b0, obs_done}, 32'h0);
    idle(2);

    // Single write command
    step(1'b1, 8'h01, 23'h000003, 1'b0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      step(1'b0, 8'h00, 23'h0, 1'b0, 1'b0);
      seen_gpo[k] = obs_gpo; seen_done[k] = obs_done;
    end
    check("t2_gpo_n2", seen_gpo[2], 32'h01000003);
    check("t2_gpo_n3", seen_gpo[3], 32'h01000003);
    check("t2_gpo_n4", seen_gpo[4], 32'h01800003);
    check("t2_gpo_n5", seen_gpo[5], 32'h01000003);
    check("t2_gpo_n6", seen_gpo[6], 32'h01000003);
    check("t2_done_n6", {31'b0, seen_done[6]}, 32'h0);
    check("t2_done_n7", {31'b0, seen_done[7]}, 32'h1);
    check("t2_done_n8", {31'b0, seen_done[8]}, 32'h0);
    idle(4);

    // Read command with fixed readback word
    gpi_force = 1'b1; gpi_val = 32'hCAFE0012;
    step(1'b1, 8'h04, 23'h010005, 1'b1, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      step(1'b0, 8'h00, 23'h0, 1'b0, 1'b0);
      seen_gpo[k] = obs_gpo; seen_done[k] = obs_done;
      seen_rv[k] = obs_rvalid; seen_rd[k] = obs_rdata;
    end
    gpi_force = 1'b0;
    check("t3_gpo_n4", seen_gpo[4], 32'h04810005);
`ifdef GPIO_CMD_MASTER_RDBK_EN
    check("t3_done_n7", {31'b0, seen_done[7]}, 32'h0);
    check("t3_done_n9", {31'b0, seen_done[9]}, 32'h1);
    check("t3_rvalid_n9", {31'b0, seen_rv[9]}, 32'h1);
    check("t3_rdata_n9", seen_rd[9], 32'hCAFE0012);
`else
    check("t6_done_n7", {31'b0, seen_done[7]}, 32'h1);
    check("t6_rvalid_n9", {31'b0, seen_rv[9]}, 32'h0);
    check("t6_rdata_n9", seen_rd[9], 32'h0);
`endif
    idle(4);

    // Six consecutive pushes into a depth-4 queue
    n_strobes = 0; n_long = 0; strobe_ops.delete(); r5 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tries = 0;
      do begin
        step(1'b1, 8'(8'h10 + k), 23'($urandom()), 1'b0, 1'b0);
        tries++;
        if (k == 5 && tries == 1) r5 = obs_ready;
      end while (!acc && tries < 60);
      check("t4_accept", {31'b0, acc}, 32'h1);
    end
    check("t4_ready_full", {31'b0, r5}, 32'h0);
    idle(60);
    check("t4_strobes", n_strobes, 6);
    check("t4_long_strobe", n_long, 0);
    for (int k = 0; k < 6; k++)
      check("t4_order", {24'b0, (k < strobe_ops.size()) ? strobe_ops[k] : 8'hxx}, 32'(8'h10 + k));

    // Reset during the first strobe of two queued commands
    step(1'b1, 8'h21, 23'h0, 1'b0, 1'b0);
    step(1'b1, 8'h22, 23'h0, 1'b0, 1'b0);
    idle(2);
    step(1'b0, 8'h00, 23'h0, 1'b0, 1'b1);
    check("t5_strobe", obs_gpo, 32'h21800000);
    n_strobes = 0; dcount = 0; bcount = 0;
    step(1'b0, 8'h00, 23'h0, 1'b0, 1'b0);
    check("t5_gpo_cleared", obs_gpo, 32'h0);
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 8'h00, 23'h0, 1'b0, 1'b0);
      if (obs_done) dcount++;
      if (obs_busy) bcount++;
    end
    check("t5_strobes", n_strobes, 0);
    check("t5_dones", dcount, 0);
    check("t5_busy", bcount, 0);

    // Random traffic with occasional reset
    for (int c = 0; c < 1500; c++) begin
      rv = ($urandom_range(0, 99) < 45);
      rr = ($urandom_range(0, 299) == 0);
      step(rv, 8'($urandom()), 23'($urandom()), 1'($urandom()), rr);
    end
    idle(50);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
